// File: rtl/user_cl_top_simd_adder.sv
// Multi-lane packed adder between a FWFT input FIFO and an output FIFO, credit-limited result buffer.
// Optional macro USER_ADDER_SAT_EN switches lanes from wrapping sum+carry to saturating sum+flag.
module user_cl_top_simd_adder #(
   parameter int DATA_WIDTH  = 32,
   parameter int OP_WIDTH    = 4,
   parameter int LANES       = 4,
   parameter int PIPE_STAGES = 1,
   parameter int OUT_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  data_empty,
   output logic                  data_rd,
   input  logic [DATA_WIDTH-1:0] data_din,
   input  logic                  data_full,
   output logic                  data_wr,
   output logic [DATA_WIDTH-1:0] data_dout,
   output logic [31:0]           word_count,
   output logic [15:0]           ovf_count
);

   localparam int FW = OP_WIDTH + 1;
   localparam int RW = LANES * FW;
   localparam int PW = $clog2(OUT_DEPTH);
   localparam int CW = PW + 1;

   function automatic logic [RW-1:0] lane_sum(input logic [DATA_WIDTH-1:0] din);
      logic [RW-1:0] res;
      logic [FW-1:0] sum;
      res = {RW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         sum = {1'b0, din[2*i*OP_WIDTH +: OP_WIDTH]} + {1'b0, din[(2*i+1)*OP_WIDTH +: OP_WIDTH]};
`ifdef USER_ADDER_SAT_EN
         sum = sum[OP_WIDTH] ? {1'b1, {OP_WIDTH{1'b1}}} : sum;
`endif
         res[i*FW +: FW] = sum;
      end
      return res;
   endfunction

   // Every field MSB is the carry (wrapping) or the saturation flag, so one OR covers both modes.
   function automatic logic any_flag(input logic [RW-1:0] res);
      logic flag;
      flag = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         flag = flag | res[i*FW + OP_WIDTH];
      end
      return flag;
   endfunction

   logic                   run_r;
   logic [PIPE_STAGES-1:0] pipe_vld_r;
   logic [RW-1:0]          pipe_dat_r [PIPE_STAGES];
   logic [RW:0]            buf_mem_r  [OUT_DEPTH];
   logic [PW-1:0]          head_r;
   logic [PW-1:0]          tail_r;
   logic [CW-1:0]          buf_count_r;
   logic [31:0]            word_count_r;
   logic [15:0]            ovf_count_r;
   logic [31:0]            credit_used_s;
   logic                   push_s;
   logic                   pop_s;

   // Credits in use: buffered results plus every valid pipeline stage.
   always_comb begin
      credit_used_s = 32'(buf_count_r);
      for (int s = 0; s < PIPE_STAGES; s++) begin
         credit_used_s = credit_used_s + 32'(pipe_vld_r[s]);
      end
   end

   assign data_rd    = run_r && !data_empty && (credit_used_s < 32'(OUT_DEPTH));
   assign data_wr    = (buf_count_r != CW'(0)) && !data_full;
   assign push_s     = pipe_vld_r[PIPE_STAGES-1];
   assign pop_s      = data_wr;
   assign data_dout  = DATA_WIDTH'(buf_mem_r[head_r][RW-1:0]);
   assign word_count = word_count_r;
   assign ovf_count  = ovf_count_r;

   // Run flag keeps data_rd low while reset is asserted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // Adder pipeline: lane sums are formed on issue, then shifted with their valid bits.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld_r <= {PIPE_STAGES{1'b0}};
         for (int s = 0; s < PIPE_STAGES; s++) begin
            pipe_dat_r[s] <= {RW{1'b0}};
         end
      end else begin
         pipe_vld_r[0] <= data_rd;
         if (data_rd) begin
            pipe_dat_r[0] <= lane_sum(data_din);
         end
         for (int s = 1; s < PIPE_STAGES; s++) begin
            pipe_vld_r[s] <= pipe_vld_r[s-1];
            pipe_dat_r[s] <= pipe_dat_r[s-1];
         end
      end
   end

   // Circular result buffer; credits guarantee a push never meets a full buffer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_r      <= PW'(0);
         tail_r      <= PW'(0);
         buf_count_r <= CW'(0);
         for (int e = 0; e < OUT_DEPTH; e++) begin
            buf_mem_r[e] <= {(RW+1){1'b0}};
         end
      end else begin
         if (push_s) begin
            buf_mem_r[tail_r] <= {any_flag(pipe_dat_r[PIPE_STAGES-1]), pipe_dat_r[PIPE_STAGES-1]};
            tail_r            <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   buf_count_r <= buf_count_r + CW'(1);
            2'b01:   buf_count_r <= buf_count_r - CW'(1);
            default: buf_count_r <= buf_count_r;
         endcase
      end
   end

   // Output statistics: word_count wraps, ovf_count saturates.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word_count_r <= 32'd0;
         ovf_count_r  <= 16'd0;
      end else begin
         if (data_wr) begin
            word_count_r <= word_count_r + 32'd1;
            if (buf_mem_r[head_r][RW] && (ovf_count_r != 16'hFFFF)) begin
               ovf_count_r <= ovf_count_r + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_user_cl_top_simd_adder.sv
// Self-checking bench for user_cl_top_simd_adder: FWFT source model, randomized output stalls,
// arithmetic reference model for lane sums and overflow counting.
module tb_user_cl_top_simd_adder;

   localparam int DW    = 32;
   localparam int OP_W  = 4;
   localparam int LANES = 4;
   localparam int PIPE  = 1;
   localparam int DEPTH = 4;

   logic        clock;
   logic        reset_n;
   logic        data_empty;
   logic        data_rd;
   logic [31:0] data_din;
   logic        data_full;
   logic        data_wr;
   logic [31:0] data_dout;
   logic [31:0] word_count;
   logic [15:0] ovf_count;

   int checks = 0;
   int errors = 0;

   typedef struct { int c; logic [31:0] d; } ev_t;
   ev_t         rd_log[$];
   ev_t         wr_log[$];
   logic [31:0] src_q[$];
   int          cyc = 0;
   bit          popped = 1'b0;
   bit          log_en = 1'b1;
   bit          full_hold = 1'b0;
   int          bubble_pct = 0;
   int          full_pct = 0;

   user_cl_top_simd_adder #(
      .DATA_WIDTH(DW), .OP_WIDTH(OP_W), .LANES(LANES), .PIPE_STAGES(PIPE), .OUT_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset_n(reset_n), .data_empty(data_empty), .data_rd(data_rd),
      .data_din(data_din), .data_full(data_full), .data_wr(data_wr), .data_dout(data_dout),
      .word_count(word_count), .ovf_count(ovf_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: each lane is plain integer a+b, clamped when saturation is built in.
   function automatic logic [31:0] model_sum(input logic [31:0] w);
      logic [63:0] r;
      int a, b, s;
      r = 64'd0;
      for (int i = 0; i < LANES; i++) begin
         a = int'(w >> (2*i*OP_W)) & ((1 << OP_W) - 1);
         b = int'(w >> ((2*i+1)*OP_W)) & ((1 << OP_W) - 1);
         s = a + b;
`ifdef USER_ADDER_SAT_EN
         if (s > (1 << OP_W) - 1) s = (1 << OP_W) + (1 << OP_W) - 1;
`endif
         r = r + (64'(s) << (i*(OP_W+1)));
      end
      return r[31:0];
   endfunction

   function automatic bit model_ovf(input logic [31:0] w);
      int a, b;
      bit f;
      f = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         a = int'(w >> (2*i*OP_W)) & ((1 << OP_W) - 1);
         b = int'(w >> ((2*i+1)*OP_W)) & ((1 << OP_W) - 1);
         if (a + b > (1 << OP_W) - 1) f = 1'b1;
      end
      return f;
   endfunction

   // Observe handshakes mid-cycle.
   initial forever begin
      @(negedge clock);
      cyc = cyc + 1;
      popped = data_rd;
      if (log_en && data_rd) rd_log.push_back('{c: cyc, d: data_din});
      if (log_en && data_wr) wr_log.push_back('{c: cyc, d: data_dout});
   end

   // Input FIFO (first-word-fall-through) and output FIFO full model.
   initial forever begin
      @(posedge clock);
      #1;
      if (popped && src_q.size() > 0) void'(src_q.pop_front());
      popped = 1'b0;
      data_empty = (src_q.size() == 0) || ($urandom_range(99) < bubble_pct);
      data_din   = data_empty ? $urandom : src_q[0];
      data_full  = full_hold || ($urandom_range(99) < full_pct);
   end

   task automatic sync();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_log.delete();
   endtask

   task automatic wait_writes(input int n, input int budget, input string name);
      for (int k = 0; k < budget; k++) begin
         sync();
         if (wr_log.size() >= n) break;
      end
      if (wr_log.size() < n) begin
         errors++;
         $display("FAIL %s timeout: writes %0d, required %0d", name, wr_log.size(), n);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({data_rd, data_wr, data_dout, word_count, ovf_count} !== 82'd0) begin
         errors++;
         $display("FAIL reset_outputs: rd=%0b wr=%0b dout=%h wc=%0d oc=%0d, required all 0",
                  data_rd, data_wr, data_dout, word_count, ovf_count);
      end
      repeat (3) sync();
      reset_n = 1'b1;
      repeat (3) sync();
   endtask

   task automatic test_single();
      int wc0, oc0;
      sync();
      clear_logs();
      wc0 = int'(word_count);
      oc0 = int'(ovf_count);
      src_q.push_back(32'h0000_4321);
      wait_writes(1, 20, "single");
      repeat (3) sync();
      checks++;
      if (rd_log.size() != 1 || wr_log.size() != 1) begin
         errors++;
         $display("FAIL single_counts: rd %0d wr %0d, required 1 1", rd_log.size(), wr_log.size());
      end else begin
         checks++;
         if (wr_log[0].c - rd_log[0].c != PIPE + 1) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required %0d", wr_log[0].c - rd_log[0].c, PIPE + 1);
         end
         checks++;
         if (wr_log[0].d !== 32'h0000_00E3) begin
            errors++;
            $display("FAIL single_data: %h, required 000000e3", wr_log[0].d);
         end
      end
      checks++;
      if (int'(word_count) != wc0 + 1 || int'(ovf_count) != oc0) begin
         errors++;
         $display("FAIL single_stats: wc %0d oc %0d, required %0d %0d", word_count, ovf_count, wc0 + 1, oc0);
      end
   endtask

   task automatic test_all_ones();
      int oc0;
      logic [31:0] exp;
`ifdef USER_ADDER_SAT_EN
      exp = 32'h000F_FFFF;
`else
      exp = 32'h000F_7BDE;
`endif
      sync();
      clear_logs();
      oc0 = int'(ovf_count);
      src_q.push_back(32'hFFFF_FFFF);
      wait_writes(1, 20, "all_ones");
      repeat (2) sync();
      checks++;
      if (wr_log.size() != 1 || wr_log[0].d !== exp) begin
         errors++;
         $display("FAIL all_ones_data: %h (n=%0d), required %h", (wr_log.size() > 0) ? wr_log[0].d : 32'hx,
                  wr_log.size(), exp);
      end
      checks++;
      if (int'(ovf_count) != oc0 + 1) begin
         errors++;
         $display("FAIL all_ones_ovf: %0d, required %0d", ovf_count, oc0 + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words[$];
      bit ok_rd, ok_wr;
      sync();
      clear_logs();
      for (int i = 0; i < 16; i++) begin
         words.push_back($urandom);
         src_q.push_back(words[i]);
      end
      wait_writes(16, 60, "b2b");
      repeat (3) sync();
      checks++;
      if (rd_log.size() != 16 || wr_log.size() != 16) begin
         errors++;
         $display("FAIL b2b_counts: rd %0d wr %0d, required 16 16", rd_log.size(), wr_log.size());
      end else begin
         ok_rd = 1'b1;
         ok_wr = 1'b1;
         for (int i = 0; i < 16; i++) begin
            if (rd_log[i].c != rd_log[0].c + i) ok_rd = 1'b0;
            if (wr_log[i].c != rd_log[0].c + PIPE + 1 + i) ok_wr = 1'b0;
         end
         checks++;
         if (!ok_rd || !ok_wr) begin
            errors++;
            $display("FAIL b2b_timing: rd consecutive %0b wr consecutive at +2 %0b, required 1 1", ok_rd, ok_wr);
         end
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_log[i].d !== model_sum(words[i])) begin
               errors++;
               $display("FAIL b2b_data[%0d]: %h, required %h", i, wr_log[i].d, model_sum(words[i]));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] words[$];
      sync();
      full_hold = 1'b1;
      clear_logs();
      for (int i = 0; i < 8; i++) begin
         words.push_back($urandom);
         src_q.push_back(words[i]);
      end
      repeat (20) sync();
      checks++;
      if (rd_log.size() != DEPTH || wr_log.size() != 0) begin
         errors++;
         $display("FAIL bp_hold: rd %0d wr %0d, required %0d 0", rd_log.size(), wr_log.size(), DEPTH);
      end
      full_hold = 1'b0;
      wait_writes(8, 60, "bp_release");
      repeat (5) sync();
      checks++;
      if (wr_log.size() != 8) begin
         errors++;
         $display("FAIL bp_count: %0d writes, required 8", wr_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_log[i].d !== model_sum(words[i])) begin
               errors++;
               $display("FAIL bp_data[%0d]: %h, required %h", i, wr_log[i].d, model_sum(words[i]));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] words[$];
      logic [31:0] w;
      int wc0, oc0, novf, bad;
      sync();
      clear_logs();
      wc0 = int'(word_count);
      oc0 = int'(ovf_count);
      novf = 0;
      bubble_pct = 30;
      full_pct = 30;
      for (int i = 0; i < 200; i++) begin
         w = $urandom;
         if ($urandom_range(3) == 0) w = w | (32'h0000_0088 << (8 * $urandom_range(3)));
         if (model_ovf(w)) novf++;
         words.push_back(w);
         src_q.push_back(w);
      end
      wait_writes(200, 3000, "random");
      bubble_pct = 0;
      full_pct = 0;
      repeat (5) sync();
      checks++;
      if (wr_log.size() != 200) begin
         errors++;
         $display("FAIL rand_count: %0d writes, required 200", wr_log.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 200; i++) begin
            if (wr_log[i].d !== model_sum(words[i])) begin
               bad++;
               if (bad < 4) $display("FAIL rand_data[%0d]: %h, required %h", i, wr_log[i].d, model_sum(words[i]));
            end
         end
         checks++;
         if (bad != 0) errors++;
      end
      checks++;
      if (int'(word_count) != wc0 + 200 || int'(ovf_count) != oc0 + novf) begin
         errors++;
         $display("FAIL rand_stats: wc %0d oc %0d, required %0d %0d", word_count, ovf_count, wc0 + 200, oc0 + novf);
      end
   endtask

   task automatic test_mid_reset();
      sync();
      full_hold = 1'b1;
      clear_logs();
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      repeat (6) sync();
      reset_n = 1'b0;
      src_q.delete();
      #1;
      checks++;
      if ({data_rd, data_wr, data_dout, word_count, ovf_count} !== 82'd0) begin
         errors++;
         $display("FAIL midrst_outputs: rd=%0b wr=%0b dout=%h wc=%0d oc=%0d, required all 0",
                  data_rd, data_wr, data_dout, word_count, ovf_count);
      end
      sync();
      reset_n = 1'b1;
      full_hold = 1'b0;
      clear_logs();
      repeat (10) sync();
      checks++;
      if (wr_log.size() != 0 || word_count !== 32'd0 || ovf_count !== 16'd0) begin
         errors++;
         $display("FAIL midrst_stale: writes %0d wc %0d oc %0d, required 0 0 0", wr_log.size(), word_count, ovf_count);
      end
      src_q.push_back(32'h0000_4321);
      wait_writes(1, 20, "midrst_recover");
      checks++;
      if (wr_log.size() != 1 || wr_log[0].d !== 32'h0000_00E3) begin
         errors++;
         $display("FAIL midrst_recover: writes %0d, required one word 000000e3", wr_log.size());
      end
   endtask

   task automatic test_saturation();
      int wc0;
      sync();
      log_en = 1'b0;
      wc0 = int'(word_count);
      for (int i = 0; i < 70000; i++) src_q.push_back($urandom | 32'h0000_0088);
      for (int k = 0; k < 72000; k++) begin
         sync();
         if (src_q.size() == 0) break;
      end
      repeat (10) sync();
      checks++;
      if (src_q.size() != 0) begin
         errors++;
         $display("FAIL sat_timeout: %0d words not consumed, required 0", src_q.size());
      end
      checks++;
      if (ovf_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_ovf: %h, required ffff", ovf_count);
      end
      checks++;
      if (int'(word_count) != wc0 + 70000) begin
         errors++;
         $display("FAIL sat_words: %0d, required %0d", word_count, wc0 + 70000);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      data_empty = 1'b0;
      data_full  = 1'b0;
      data_din   = 32'h0000_4321;
      test_reset();
      test_single();
      test_all_ones();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/user_cl_top_simd_adder.md
# user_cl_top_simd_adder

Parametrised multi-lane adder between an input FIFO and an output FIFO in the custom-logic region. Each input word carries LANES operand pairs; all lane sums for that word are packed into one output word. The block is fully pipelined at one word per clock and holds results in an internal result buffer. A credit check stops it reading new words when the buffer cannot accept more, so no result is ever dropped while the output FIFO is full.

## Interface
- DATA_WIDTH, 32, FIFO word width; 2*LANES*OP_WIDTH <= DATA_WIDTH.
- OP_WIDTH, 4, operand width per lane.
- LANES, 4, operand pairs per word.
- PIPE_STAGES, 1, adder pipeline registers, >= 1.
- OUT_DEPTH, 4, result buffer entries, power of 2, >= PIPE_STAGES+2.
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_empty  in  1  input FIFO empty (first-word-fall-through: data_din is valid whenever low).
- data_rd  out  1  pops data_din in the same cycle.
- data_din  in  DATA_WIDTH  operand word.
- data_full  in  1  output FIFO full.
- data_wr  out  1  writes data_dout in the same cycle.
- data_dout  out  DATA_WIDTH  packed lane results.
- word_count  out  32  words written out; wraps at 2^32.
- ovf_count  out  16  words written with any lane carry/overflow; saturates at 0xFFFF.

## Operation
- Lane i operands:
  - a = data_din[(2i)*OP_WIDTH +: OP_WIDTH]
  - b = data_din[(2i+1)*OP_WIDTH +: OP_WIDTH]
- Lane i result occupies data_dout[i*(OP_WIDTH+1) +: OP_WIDTH+1]. Unused upper bits are 0.
- Default arithmetic: each field holds the unsigned sum a+b, which is OP_WIDTH+1 bits, so the MSB is the carry.
- Issue rule: data_rd = !data_empty && (buf_count + inflight < OUT_DEPTH), both counts taken from registers.
  - inflight is the number of valid pipeline stages.
  - A buffer pop in the same cycle does not free a credit until the next cycle.
- Pipeline: a stage-valid bit travels with the data. The last stage writes into the result buffer (circular, head/tail pointers, buf_count).
- Writer: data_wr = (buf_count != 0) && !data_full. data_dout = head entry (registered storage); the head is popped on data_wr.
- Push and pop may happen in the same cycle; buf_count is then unchanged.
- word_count increments on data_wr. ovf_count increments on data_wr when any lane of the head entry flagged a carry/overflow.

## Timing
- Reset (asynchronous assert):
  - All pipeline valids, pointers, buf_count and counters clear to 0.
  - Buffer entries clear to 0.
  - Outputs: data_rd=0, data_wr=0, data_dout=0, word_count=0, ovf_count=0.
- Reset asserted mid-operation: in-flight and buffered words are discarded and never written. Words already popped from the input FIFO are lost.
- Latency: data_rd in cycle T gives the earliest data_wr in cycle T+PIPE_STAGES+1.
- Throughput: one word per clock while data_full=0, given OUT_DEPTH >= PIPE_STAGES+2.
- data_full held high: data_rd stops after OUT_DEPTH words are outstanding. Output resumes the cycle data_full drops, in input order.
- data_empty high: no pop. data_din is ignored.

## Configuration
- USER_ADDER_SAT_EN defined:
  - Field low OP_WIDTH bits hold min(a+b, 2^OP_WIDTH-1).
  - Field MSB is set when the lane saturated.
  - ovf_count counts words where any lane saturated.
- USER_ADDER_SAT_EN undefined: wrapping sum with the carry as the field MSB, as described in Operation.

## Test plan
- Default parameters, data_din=0x00004321, data_full=0: data_rd high in cycle T; data_wr high in cycle T+2 with data_dout=0x000000E3; word_count=1; ovf_count=0.
- data_din=0xFFFFFFFF:
  - Without the macro: data_dout=0x000F7BDE and ovf_count=1.
  - With USER_ADDER_SAT_EN: data_dout=0x000FFFFF and ovf_count=1.
- 16 back-to-back words with data_full=0: data_rd high 16 consecutive cycles; data_wr high 16 consecutive cycles starting 2 cycles later; results in order.
- data_full=1 while 8 words are queued: exactly 4 data_rd pulses, no data_wr. Release data_full: all 8 results emerge in order with none lost or duplicated.
- Pull reset_n low for one cycle with 3 words in flight or buffered: outputs are 0 immediately, no stale data_wr after release, counters read 0.
- 70000 words each with a carry: ovf_count holds at 0xFFFF; word_count reads 70000.
